// File: rtl/req_gnt_tracker.sv
// Request/grant tracker: queues request ids in order and returns one registered
// gnt pulse per accepted request after LAT wait cycles. Optional assertions: TRACKER_SVA_EN.
module req_gnt_tracker #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4,
  parameter int LAT   = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [ID_W-1:0]            req_id_i,
  input  logic                       hold_i,
  output logic                       gnt_o,
  output logic [ID_W-1:0]            gnt_id_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH+1);
  localparam int CNT_W   = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;

  logic [ID_W-1:0]    fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic               overflow_q;

  logic               full, empty, push, pop, drop;

  // Full/empty come from the registered occupancy, so a push on the same edge
  // as a pop at full is still rejected.
  assign full  = (count_q == COUNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = req_i && !full;
  assign drop  = req_i && full;
  assign pop   = (state_q == S_GRANT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= req_id_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(LAT - 1);
        end
      end
      S_WAIT: begin
        if (!hold_i) begin
          if (cnt_q == '0) state_d = S_GRANT;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_GRANT: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The grant is registered on the edge entering GRANT, so gnt is high exactly
  // while the FSM sits in GRANT; the head entry is stable until the exit pop.
  always_comb begin
    gnt_d    = (state_d == S_GRANT);
    gnt_id_d = gnt_id_q;
    if (state_d == S_GRANT) gnt_id_d = fifo_q[rd_ptr_q];
  end

  assign gnt_o      = gnt_q;
  assign gnt_id_o   = gnt_id_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

`ifdef TRACKER_SVA_EN
  // Id match only holds when requesters use unique ids and nothing is dropped.
  property p_id_match;
    logic [ID_W-1:0] l;
    @(posedge clk_i) disable iff (!rst_ni)
      ($rose(req_i), l = req_id_i) |-> ##[1:$] ($rose(gnt_o) ##0 (gnt_id_o == l));
  endproperty

  a_id_match: assert property (p_id_match)
    else $error("req_gnt_tracker: granted id does not match requested id");
  a_gnt_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_o |=> !gnt_o)
    else $error("req_gnt_tracker: gnt high for more than one cycle");
  a_full_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(full_o && empty_o))
    else $error("req_gnt_tracker: full and empty together");
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count_o <= COUNT_W'(DEPTH))
    else $error("req_gnt_tracker: count exceeds DEPTH");
`else
`endif

endmodule
